// File: rtl/inst_fetch_arbiter_if.sv
// Bundles the fetch-way handshakes, flush and instruction-memory port of the
// fetch arbiter. The master modport is the arbiter's view; slave is its environment.
interface inst_fetch_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              flush_i;

    logic              way0_req_i;
    logic [ADDR_W-1:0] way0_addr_i;
    logic              way0_ready_i;
    logic              way0_gnt_o;
    logic              way0_valid_o;
    logic [DATA_W-1:0] way0_inst_o;
    logic [ADDR_W-1:0] way0_addr_o;

    logic              way1_req_i;
    logic [ADDR_W-1:0] way1_addr_i;
    logic              way1_ready_i;
    logic              way1_gnt_o;
    logic              way1_valid_o;
    logic [DATA_W-1:0] way1_inst_o;
    logic [ADDR_W-1:0] way1_addr_o;

    logic              mem_req_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_gnt_i;
    logic              mem_rvalid_i;
    logic [DATA_W-1:0] mem_rdata_i;

    modport master (
        input  flush_i,
        input  way0_req_i, way0_addr_i, way0_ready_i,
        output way0_gnt_o, way0_valid_o, way0_inst_o, way0_addr_o,
        input  way1_req_i, way1_addr_i, way1_ready_i,
        output way1_gnt_o, way1_valid_o, way1_inst_o, way1_addr_o,
        output mem_req_o, mem_addr_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );

    modport slave (
        output flush_i,
        output way0_req_i, way0_addr_i, way0_ready_i,
        input  way0_gnt_o, way0_valid_o, way0_inst_o, way0_addr_o,
        output way1_req_i, way1_addr_i, way1_ready_i,
        input  way1_gnt_o, way1_valid_o, way1_inst_o, way1_addr_o,
        input  mem_req_o, mem_addr_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );
endinterface

// File: rtl/inst_fetch_arbiter.sv
// Round-robin arbiter sharing one instruction-memory port between two fetch
// ways, one transaction in flight, with flush cancellation and response backpressure.
module inst_fetch_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    inst_fetch_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DELIVER} state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_owner_q, last_owner_d;
    logic              drop_q, drop_d;
    logic              mem_req_q;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              load_rsp;
    logic              sel;

    logic [1:0]        req_w;
    logic [1:0]        ready_w;
    logic              gnt_w     [2];
    logic [ADDR_W-1:0] addr_in_w [2];
    logic              valid_q   [2];
    logic [DATA_W-1:0] inst_q    [2];
    logic [ADDR_W-1:0] addr_q    [2];

    assign req_w        = {bus.way1_req_i, bus.way0_req_i};
    assign ready_w      = {bus.way1_ready_i, bus.way0_ready_i};
    assign addr_in_w[0] = bus.way0_addr_i;
    assign addr_in_w[1] = bus.way1_addr_i;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        drop_d       = drop_q;
        mem_addr_d   = mem_addr_q;
        load_rsp     = 1'b0;
        // On a tie the way that did not last complete a delivery wins.
        sel          = (&req_w) ? ~last_owner_q : req_w[1];
        case (state_q)
            IDLE: begin
                if (|req_w) begin
                    owner_d    = sel;
                    mem_addr_d = addr_in_w[sel];
                    drop_d     = 1'b0;
                    state_d    = REQ;
                end
            end
            REQ: begin
                if (bus.mem_gnt_i) begin
                    drop_d  = bus.flush_i;
                    state_d = WAIT;
                end else if (bus.flush_i) begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (bus.mem_rvalid_i) begin
                    drop_d = 1'b0;
                    if (drop_q || bus.flush_i) begin
                        state_d = IDLE;
                    end else begin
                        load_rsp = 1'b1;
                        state_d  = DELIVER;
                    end
                end else if (bus.flush_i) begin
                    drop_d = 1'b1;
                end
            end
            DELIVER: begin
                // A transfer coinciding with a flush still counts as delivered.
                if (ready_w[owner_q]) begin
                    last_owner_d = owner_q;
                    state_d      = IDLE;
                end else if (bus.flush_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            drop_q       <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            drop_q       <= drop_d;
            mem_req_q    <= (state_d == REQ);
            mem_addr_q   <= mem_addr_d;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_way
            assign gnt_w[gi] = (state_q == REQ) && bus.mem_gnt_i && (owner_q == 1'(gi));

            // These registers double as the response register for this way.
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    valid_q[gi] <= 1'b0;
                    inst_q[gi]  <= '0;
                    addr_q[gi]  <= '0;
                end else begin
                    valid_q[gi] <= (state_d == DELIVER) && (owner_d == 1'(gi));
                    if (load_rsp && (owner_q == 1'(gi))) begin
                        inst_q[gi] <= bus.mem_rdata_i;
                        addr_q[gi] <= mem_addr_q;
                    end
                end
            end
        end
    endgenerate

    assign bus.mem_req_o    = mem_req_q;
    assign bus.mem_addr_o   = mem_addr_q;
    assign bus.way0_gnt_o   = gnt_w[0];
    assign bus.way0_valid_o = valid_q[0];
    assign bus.way0_inst_o  = inst_q[0];
    assign bus.way0_addr_o  = addr_q[0];
    assign bus.way1_gnt_o   = gnt_w[1];
    assign bus.way1_valid_o = valid_q[1];
    assign bus.way1_inst_o  = inst_q[1];
    assign bus.way1_addr_o  = addr_q[1];
endmodule

// File: tb/tb_inst_fetch_arbiter.sv
// Directed bench for inst_fetch_arbiter: single fetch, round-robin, backpressure,
// flush in REQ/WAIT, flush with grant and reset in WAIT.
module tb_inst_fetch_arbiter;
    logic clk;
    logic reset_n;
    int   errors;
    int   checks;

    inst_fetch_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    inst_fetch_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_mem_req"},  64'(bus.mem_req_o), 64'd0);
        chk({tag, "_mem_addr"}, 64'(bus.mem_addr_o), 64'd0);
        chk({tag, "_valid"},    64'({bus.way1_valid_o, bus.way0_valid_o}), 64'd0);
        chk({tag, "_gnt"},      64'({bus.way1_gnt_o, bus.way0_gnt_o}), 64'd0);
        chk({tag, "_inst"},     {bus.way1_inst_o, bus.way0_inst_o}, 64'd0);
        chk({tag, "_addr"},     {bus.way1_addr_o, bus.way0_addr_o}, 64'd0);
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        reset_n = 1'b0;
        bus.flush_i      = 1'b0;
        bus.way0_req_i   = 1'b0;
        bus.way0_addr_i  = '0;
        bus.way0_ready_i = 1'b1;
        bus.way1_req_i   = 1'b0;
        bus.way1_addr_i  = '0;
        bus.way1_ready_i = 1'b1;
        bus.mem_gnt_i    = 1'b0;
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = '0;
        tick();
        tick();
        chk_reset_vals("reset");

        // Single request from way0
        reset_n         = 1'b1;
        bus.way0_req_i  = 1'b1;
        bus.way0_addr_i = 32'h1000;
        tick();
        chk("single_mem_req", 64'(bus.mem_req_o), 64'd1);
        chk("single_mem_addr", 64'(bus.mem_addr_o), 64'h1000);
        bus.mem_gnt_i = 1'b1;
        #1;
        chk("single_gnt", 64'({bus.way1_gnt_o, bus.way0_gnt_o}), 64'b01);
        tick();
        bus.way0_req_i   = 1'b0;
        bus.mem_gnt_i    = 1'b0;
        bus.way0_addr_i  = 32'hFFFF;
        #1;
        chk("single_gnt_once", 64'({bus.way1_gnt_o, bus.way0_gnt_o}), 64'b00);
        chk("single_req_drop", 64'(bus.mem_req_o), 64'd0);
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 32'hDEADBEEF;
        tick();
        bus.mem_rvalid_i = 1'b0;
        chk("single_valid", 64'({bus.way1_valid_o, bus.way0_valid_o}), 64'b01);
        chk("single_inst", 64'(bus.way0_inst_o), 64'hDEADBEEF);
        chk("single_addr", 64'(bus.way0_addr_o), 64'h1000);
        chk("single_way1_quiet", {bus.way1_inst_o, bus.way1_addr_o}, 64'd0);
        tick();
        chk("single_valid_drop", 64'(bus.way0_valid_o), 64'd0);
        chk("single_inst_hold", 64'(bus.way0_inst_o), 64'hDEADBEEF);

        // Round-robin after a reset so way0 wins the first tie
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        bus.way0_req_i  = 1'b1;
        bus.way0_addr_i = 32'h2000;
        bus.way1_req_i  = 1'b1;
        bus.way1_addr_i = 32'h3000;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("rr%0d_mem_addr", i), 64'(bus.mem_addr_o),
                (i % 2 == 1) ? 64'h3000 : 64'h2000);
            bus.mem_gnt_i = 1'b1;
            #1;
            chk($sformatf("rr%0d_gnt", i), 64'({bus.way1_gnt_o, bus.way0_gnt_o}),
                (i % 2 == 1) ? 64'b10 : 64'b01);
            tick();
            bus.mem_gnt_i    = 1'b0;
            bus.mem_rvalid_i = 1'b1;
            bus.mem_rdata_i  = 32'hA000_0000 + 32'(i);
            tick();
            bus.mem_rvalid_i = 1'b0;
            chk($sformatf("rr%0d_valid", i), 64'({bus.way1_valid_o, bus.way0_valid_o}),
                (i % 2 == 1) ? 64'b10 : 64'b01);
            chk($sformatf("rr%0d_inst", i),
                (i % 2 == 1) ? 64'(bus.way1_inst_o) : 64'(bus.way0_inst_o),
                64'hA000_0000 + 64'(i));
            chk($sformatf("rr%0d_addr", i),
                (i % 2 == 1) ? 64'(bus.way1_addr_o) : 64'(bus.way0_addr_o),
                (i % 2 == 1) ? 64'h3000 : 64'h2000);
            tick();
        end
        bus.way0_req_i = 1'b0;
        bus.way1_req_i = 1'b0;

        // Backpressure on way1 for 5 cycles while way0 keeps requesting
        bus.way1_req_i   = 1'b1;
        bus.way1_addr_i  = 32'h4000;
        bus.way1_ready_i = 1'b0;
        tick();
        bus.mem_gnt_i = 1'b1;
        tick();
        bus.mem_gnt_i    = 1'b0;
        bus.way1_req_i   = 1'b0;
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 32'hCAFEF00D;
        tick();
        bus.mem_rvalid_i = 1'b0;
        bus.way0_req_i   = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp%0d_valid", k), 64'({bus.way1_valid_o, bus.way0_valid_o}), 64'b10);
            chk($sformatf("bp%0d_data", k), {bus.way1_inst_o, bus.way1_addr_o},
                {32'hCAFEF00D, 32'h4000});
            chk($sformatf("bp%0d_no_mem_req", k), 64'(bus.mem_req_o), 64'd0);
            tick();
        end
        bus.way0_req_i   = 1'b0;
        bus.way1_ready_i = 1'b1;
        chk("bp_last_valid", 64'(bus.way1_valid_o), 64'd1);
        tick();
        chk("bp_done_valid", 64'({bus.way1_valid_o, bus.way0_valid_o}), 64'b00);
        tick();
        chk("bp_idle_no_req", 64'(bus.mem_req_o), 64'd0);

        // Flush while waiting; late rvalid must be discarded
        bus.way0_req_i  = 1'b1;
        bus.way0_addr_i = 32'h5000;
        tick();
        bus.mem_gnt_i = 1'b1;
        tick();
        bus.mem_gnt_i  = 1'b0;
        bus.way0_req_i = 1'b0;
        bus.flush_i    = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        tick();
        tick();
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 32'h12345678;
        tick();
        bus.mem_rvalid_i = 1'b0;
        chk("fw_valid0", 64'({bus.way1_valid_o, bus.way0_valid_o}), 64'b00);
        chk("fw_inst_hold", 64'(bus.way0_inst_o), 64'hA000_0002);
        tick();
        chk("fw_valid1", 64'({bus.way1_valid_o, bus.way0_valid_o}), 64'b00);
        chk("fw_idle", 64'(bus.mem_req_o), 64'd0);

        // Next request after the flush proceeds normally
        bus.way1_req_i  = 1'b1;
        bus.way1_addr_i = 32'h6000;
        tick();
        chk("post_mem_addr", 64'(bus.mem_addr_o), 64'h6000);
        bus.mem_gnt_i = 1'b1;
        tick();
        bus.mem_gnt_i    = 1'b0;
        bus.way1_req_i   = 1'b0;
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 32'h0000600D;
        tick();
        bus.mem_rvalid_i = 1'b0;
        chk("post_valid", 64'({bus.way1_valid_o, bus.way0_valid_o}), 64'b10);
        chk("post_inst", 64'(bus.way1_inst_o), 64'h600D);
        tick();

        // Flush together with grant: pulse still issued, response dropped
        bus.way0_req_i  = 1'b1;
        bus.way0_addr_i = 32'h7000;
        tick();
        bus.mem_gnt_i = 1'b1;
        bus.flush_i   = 1'b1;
        #1;
        chk("fg_gnt", 64'({bus.way1_gnt_o, bus.way0_gnt_o}), 64'b01);
        tick();
        bus.mem_gnt_i  = 1'b0;
        bus.flush_i    = 1'b0;
        bus.way0_req_i = 1'b0;
        chk("fg_mem_req", 64'(bus.mem_req_o), 64'd0);
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 32'hBAD0BAD0;
        tick();
        bus.mem_rvalid_i = 1'b0;
        chk("fg_valid", 64'({bus.way1_valid_o, bus.way0_valid_o}), 64'b00);
        chk("fg_inst_hold", 64'(bus.way0_inst_o), 64'hA000_0002);

        // Flush in REQ without grant: no pulse, request dropped
        bus.way1_req_i  = 1'b1;
        bus.way1_addr_i = 32'h8000;
        tick();
        chk("fr_mem_req", 64'(bus.mem_req_o), 64'd1);
        bus.flush_i = 1'b1;
        #1;
        chk("fr_no_gnt", 64'({bus.way1_gnt_o, bus.way0_gnt_o}), 64'b00);
        bus.way1_req_i = 1'b0;
        tick();
        bus.flush_i = 1'b0;
        chk("fr_req_drop", 64'(bus.mem_req_o), 64'd0);

        // Way0 delivers so way1 wins the next tie; then reset during WAIT
        bus.way0_req_i  = 1'b1;
        bus.way0_addr_i = 32'h9000;
        tick();
        bus.mem_gnt_i = 1'b1;
        tick();
        bus.mem_gnt_i    = 1'b0;
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 32'h9999;
        tick();
        bus.mem_rvalid_i = 1'b0;
        bus.way1_req_i   = 1'b1;
        bus.way1_addr_i  = 32'hA000;
        chk("rst_pre_inst", 64'(bus.way0_inst_o), 64'h9999);
        tick();
        tick();
        chk("rst_tie_way1", 64'(bus.mem_addr_o), 64'hA000);
        bus.mem_gnt_i = 1'b1;
        tick();
        bus.mem_gnt_i = 1'b0;
        reset_n       = 1'b0;
        tick();
        reset_n = 1'b1;
        chk_reset_vals("rst_wait");
        tick();
        chk("rst_tie_way0", 64'(bus.mem_addr_o), 64'h9000);
        bus.mem_gnt_i = 1'b1;
        #1;
        chk("rst_gnt_way0", 64'({bus.way1_gnt_o, bus.way0_gnt_o}), 64'b01);
        tick();
        bus.mem_gnt_i  = 1'b0;
        bus.way0_req_i = 1'b0;
        bus.way1_req_i = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
